branch_resolve_queue: RTL

- Tracks every in-flight predicted branch from decode to resolution in the memory stage.
- Decode pushes the branch PC, the prediction and the predicted target into a small FIFO.
- The memory stage resolves the oldest entry in order. The block then drives the history-table update (address, decision, strobe) and, on a mispredict, issues a flush plus the recovery PC to fetch.
- It sits between the branch predictor outputs, the pipeline resolution logic and the PC-select mux.

---
 rtl/branch_resolve_queue_if.sv | 39 +++
 rtl/branch_resolve_queue.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue_if.sv
// Branch resolve queue bus: decode enqueue, memory-stage resolve,
// history-table update, fetch redirect and status.
interface branch_resolve_queue_if #(
    parameter int PTR_W = 2
);
    logic             enq_valid;
    logic [31:0]      enq_pc;
    logic             enq_pred;
    logic [31:0]      enq_target;
    logic             enq_ready;
    logic             res_valid;
    logic             res_taken;
    logic [31:0]      res_target;
    logic             upd_valid;
    logic [31:0]      upd_addr;
    logic             upd_taken;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic [PTR_W:0]   occupancy;
    logic [15:0]      mispredict_cnt;
    logic             err_overflow;
    logic             err_underflow;

    modport master (
        output enq_valid, enq_pc, enq_pred, enq_target,
        output res_valid, res_taken, res_target,
        input  enq_ready, upd_valid, upd_addr, upd_taken,
        input  flush, redirect_pc, occupancy, mispredict_cnt,
        input  err_overflow, err_underflow
    );

    modport slave (
        input  enq_valid, enq_pc, enq_pred, enq_target,
        input  res_valid, res_taken, res_target,
        output enq_ready, upd_valid, upd_addr, upd_taken,
        output flush, redirect_pc, occupancy, mispredict_cnt,
        output err_overflow, err_underflow
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves the head entry and
// drives history update plus mispredict flush/redirect.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic                  clk,
    input logic                  reset,
    branch_resolve_queue_if.slave bus
);

    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]      pc_q  [DEPTH];
    logic [31:0]      tgt_q [DEPTH];
    logic [DEPTH-1:0] pred_q;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             upd_valid_q, upd_valid_d;
    logic [31:0]      upd_addr_q, upd_addr_d;
    logic             upd_taken_q, upd_taken_d;
    logic             flush_q, flush_d;
    logic [31:0]      redirect_q, redirect_d;
    logic [15:0]      mcnt_q, mcnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic        full, empty;
    logic        do_res, do_enq, mis;
    logic [31:0] head_pc, head_tgt;
    logic        head_pred;

    assign full      = (occ_q == OCC_FULL);
    assign empty     = (occ_q == '0);
    assign head_pc   = pc_q[rd_ptr_q];
    assign head_tgt  = tgt_q[rd_ptr_q];
    assign head_pred = pred_q[rd_ptr_q];

    assign do_res = bus.res_valid && !empty;
    assign mis    = do_res &&
                    ((head_pred != bus.res_taken) ||
                     (head_pred && bus.res_taken &&
                      (head_tgt != bus.res_target)));
    // A mispredicting resolve means any same-cycle enqueue is wrong-path.
    assign do_enq = bus.enq_valid && !full && !mis;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        occ_d       = occ_q;
        upd_valid_d = do_res;
        upd_addr_d  = upd_addr_q;
        upd_taken_d = upd_taken_q;
        flush_d     = mis;
        redirect_d  = redirect_q;
        mcnt_d      = mcnt_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;

        if (do_enq) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (do_res) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            upd_addr_d  = head_pc;
            upd_taken_d = bus.res_taken;
        end

        unique case ({do_enq, do_res})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase

        // Squash everything younger than the resolved head.
        if (mis) begin
            wr_ptr_d   = rd_ptr_q + PTR_ONE;
            occ_d      = '0;
            redirect_d = bus.res_taken ? bus.res_target
                                       : head_pc + 32'd4;
            if (mcnt_q != 16'hFFFF) begin
                mcnt_d = mcnt_q + 16'd1;
            end
        end

        if (bus.enq_valid && full && !mis) begin
            ovf_d = 1'b1;
        end

        if (bus.res_valid && empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_addr_q  <= '0;
            upd_taken_q <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            mcnt_q      <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            upd_valid_q <= upd_valid_d;
            upd_addr_q  <= upd_addr_d;
            upd_taken_q <= upd_taken_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            mcnt_q      <= mcnt_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            pc_q[wr_ptr_q]   <= bus.enq_pc;
            tgt_q[wr_ptr_q]  <= bus.enq_target;
            pred_q[wr_ptr_q] <= bus.enq_pred;
        end
    end

    assign bus.enq_ready      = !full;
    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_addr       = upd_addr_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_pc    = redirect_q;
    assign bus.occupancy      = occ_q;
    assign bus.mispredict_cnt = mcnt_q;
    assign bus.err_overflow   = ovf_q;
    assign bus.err_underflow  = udf_q;

endmodule
